// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file.
// Contents:
//   state_e - sweep FSM state (StIdle, StSweep)
//   clog2   - ceiling log2 used to size address ports
package regfile_2r1w_pkg;

  typedef enum logic {
    StIdle,
    StSweep
  } state_e;

  // Smallest r with 2**r >= n; loop form keeps it usable as a constant function.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Flop-based register file: two combinational read ports, one write port, plus a
// sequential clear sweep started by init_req.
// Ports:
//   clk       - rising-edge clock
//   clr       - asynchronous active-high reset (clears all entries)
//   we        - write enable
//   waddr     - write address
//   wdata     - write data
//   ra0, ra1  - read addresses
//   rd0, rd1  - read data (write-first bypass, zero for invalid addresses)
//   init_req  - start a clear sweep of all entries
//   busy      - high while the sweep runs; writes are dropped meanwhile
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             init_req,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_sweep;
  logic             w_last;
  logic             w_wr_en;
  logic [AW-1:0]    w_ra [2];
  logic [WIDTH-1:0] w_rd [2];

  assign w_sweep = (r_state == StSweep);
  assign busy    = w_sweep;
  assign w_last  = (32'(r_idx) == DEPTH - 1);

  // Out-of-range and (optionally) entry-0 writes are silently discarded.
  assign w_wr_en = we && !w_sweep && (32'(waddr) < DEPTH) &&
                   !(ZERO_R0 && (waddr == '0));

  // Sweep FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (init_req) begin
          w_state_nxt = StSweep;
          w_idx_nxt   = '0;
        end
      end
      StSweep: begin
        if (w_last) begin
          w_state_nxt = StIdle;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
    endcase
  end

  // Storage: the sweep owns the array while busy, so user writes cannot collide with it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_sweep) begin
          if (32'(r_idx) == i) r_mem[i] <= '0;
        end else if (w_wr_en && (32'(waddr) == i)) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  // Read ports: array lookup, then bypass, then the invalid-address rule (highest priority).
  assign w_ra[0] = ra0;
  assign w_ra[1] = ra1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (32'(w_ra[p]) == i) w_rd[p] = r_mem[i];
      end
      if (w_wr_en && (waddr == w_ra[p])) w_rd[p] = wdata;
      if ((32'(w_ra[p]) >= DEPTH) || (ZERO_R0 && (w_ra[p] == '0))) w_rd[p] = '0;
    end
  end

  assign rd0 = w_rd[0];
  assign rd1 = w_rd[1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Three instances share one stimulus bus:
//   A: defaults (WIDTH 8, DEPTH 8), Z: ZERO_R0=1, D: DEPTH 6, WIDTH 16.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge so combinational reads and bypass are observed before the commit.
module tb_regfile_2r1w;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic        init;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        eb;
  } vec_t;

  typedef struct {
    string       name;
    int          dut;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        eb;
  } exp_t;

  localparam int DutA = 0;
  localparam int DutZ = 1;
  localparam int DutD = 2;

  logic        clk;
  logic        clr;
  logic        we;
  logic        init_req;
  logic [2:0]  waddr;
  logic [2:0]  ra0;
  logic [2:0]  ra1;
  logic [15:0] wdata;
  logic [7:0]  a_rd0, a_rd1, z_rd0, z_rd1;
  logic [15:0] d_rd0, d_rd1;
  logic        a_busy, z_busy, d_busy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  regfile_2r1w u_dut_a (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .ra0(ra0), .ra1(ra1), .rd0(a_rd0), .rd1(a_rd1), .init_req(init_req), .busy(a_busy)
  );

  regfile_2r1w #(.ZERO_R0(1'b1)) u_dut_z (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .ra0(ra0), .ra1(ra1), .rd0(z_rd0), .rd1(z_rd1), .init_req(init_req), .busy(z_busy)
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6)) u_dut_d (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ra0(ra0), .ra1(ra1), .rd0(d_rd0), .rd1(d_rd1), .init_req(init_req), .busy(d_busy)
  );

  function automatic logic [15:0] rd0_of(input int dut);
    case (dut)
      DutA:    return {8'h00, a_rd0};
      DutZ:    return {8'h00, z_rd0};
      default: return d_rd0;
    endcase
  endfunction

  function automatic logic [15:0] rd1_of(input int dut);
    case (dut)
      DutA:    return {8'h00, a_rd1};
      DutZ:    return {8'h00, z_rd1};
      default: return d_rd1;
    endcase
  endfunction

  function automatic logic busy_of(input int dut);
    case (dut)
      DutA:    return a_busy;
      DutZ:    return z_busy;
      default: return d_busy;
    endcase
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [15:0] a0, a1;
    logic        ab;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: output sampled with no expectation queued");
      return;
    end
    e  = sb.pop_front();
    a0 = rd0_of(e.dut);
    a1 = rd1_of(e.dut);
    ab = busy_of(e.dut);
    if (a0 !== e.e0 || a1 !== e.e1 || ab !== e.eb) begin
      fails++;
      $display("FAIL %s: rd0=%h rd1=%h busy=%b, expected rd0=%h rd1=%h busy=%b",
               e.name, a0, a1, ab, e.e0, e.e1, e.eb);
    end
  endtask

  task automatic expect_out(input string name, input int dut, input logic [15:0] e0,
                            input logic [15:0] e1, input logic eb);
    exp_t e;
    e.name = name;
    e.dut  = dut;
    e.e0   = e0;
    e.e1   = e1;
    e.eb   = eb;
    sb.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] r0, input logic [2:0] r1, input logic in);
    @(posedge clk);
    #1;
    we       = w;
    waddr    = wa;
    wdata    = wd;
    ra0      = r0;
    ra1      = r1;
    init_req = in;
  endtask

  // One clock cycle: drive, queue the expected outputs, compare at the falling edge.
  task automatic cyc(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] r0, input logic [2:0] r1, input logic in,
                     input string name, input int dut, input logic [15:0] e0,
                     input logic [15:0] e1, input logic eb);
    drive(w, wa, wd, r0, r1, in);
    expect_out(name, dut, e0, e1, eb);
    @(negedge clk);
    pop_check();
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1;
    clr      = 1'b1;
    we       = 1'b0;
    init_req = 1'b0;
    @(negedge clk);
    #2;
    clr = 1'b0;
  endtask

  // Called right after the cycle that presented init_req; counts busy cycles (bounded).
  task automatic count_busy(input int dut, input int exp, input string name);
    int n;
    n = 0;
    drive(1'b0, 3'd0, 16'h0, ra0, ra1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_of(dut)) n++;
      else break;
    end
    check_val(name, n, exp);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] old;

    clr      = 1'b1;
    we       = 1'b0;
    waddr    = 3'd0;
    wdata    = 16'h0;
    ra0      = 3'd0;
    ra1      = 3'd0;
    init_req = 1'b0;

    //          we    waddr wdata     ra0   ra1   init  rd0       rd1       busy
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 16'h00A5, 3'd3, 3'd4, 1'b0, 16'h00A5, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 1'b0, 16'h00A5, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 3'd5, 16'h003C, 3'd5, 3'd5, 1'b0, 16'h003C, 16'h003C, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 1'b0, 16'h003C, 16'h00A5, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 16'h005A, 3'd3, 3'd5, 1'b0, 16'h005A, 16'h003C, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 16'h005A, 16'h005A, 1'b0};
    vecs[7] = '{1'b1, 3'd0, 16'h00FF, 3'd0, 3'd1, 1'b0, 16'h00FF, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 16'h00FF, 16'h0000, 1'b0};

    // Reset state while clr is held, no clock dependence.
    repeat (2) @(negedge clk);
    expect_out("reset_held", DutA, 16'h0, 16'h0, 1'b0);
    pop_check();
    #2;
    clr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, "reset_read", DutA, 16'h0, 16'h0, 1'b0);
    end

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1, vecs[i].init,
          $sformatf("vec%0d", i), DutA, vecs[i].e0, vecs[i].e1, vecs[i].eb);
    end

    // ZERO_R0: entry 0 stays zero, also during the write cycle.
    clr_pulse();
    cyc(1'b1, 3'd0, 16'h00FF, 3'd0, 3'd0, 1'b0, "z_r0_wr", DutZ, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, "z_r0_rd", DutZ, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 3'd1, 16'h00C3, 3'd1, 3'd0, 1'b0, "z_r1_byp", DutZ, 16'h00C3, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd1, 3'd1, 1'b0, "z_r1_rd", DutZ, 16'h00C3, 16'h00C3, 1'b0);

    // Fill, then sweep with a dropped write, a same-cycle write and an ignored init_req.
    clr_pulse();
    for (int i = 0; i < 8; i++) begin
      v = 16'(17 * (i + 1));
      cyc(1'b1, 3'(i), v, 3'(i), 3'((i + 7) % 8), 1'b0, "fill", DutA,
          v, (i == 0) ? 16'h0 : 16'(17 * i), 1'b0);
    end
    cyc(1'b1, 3'd1, 16'h00EE, 3'd1, 3'd2, 1'b1, "init_cycle", DutA, 16'h00EE, 16'h0033, 1'b0);
    cyc(1'b1, 3'd2, 16'h0077, 3'd0, 3'd2, 1'b0, "sweep0_drop", DutA, 16'h0011, 16'h0033, 1'b1);
    for (int k = 1; k < 8; k++) begin
      old = (k == 1) ? 16'h00EE : 16'(17 * (k + 1));
      cyc(1'b0, 3'd0, 16'h0, 3'(k), 3'(k - 1), (k == 4), $sformatf("sweep%0d", k), DutA,
          old, 16'h0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, "post_sweep", DutA, 16'h0, 16'h0, 1'b0);
    end

    // DEPTH 6 / WIDTH 16: out-of-range addresses and a 6-cycle sweep.
    clr_pulse();
    cyc(1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd6, 1'b0, "d6_oor_wr", DutD, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 1'b0, "d6_oor_rd", DutD, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 3'd5, 16'h1234, 3'd5, 3'd7, 1'b0, "d6_top_wr", DutD, 16'h1234, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 1'b0, "d6_top_rd", DutD, 16'h1234, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 1'b1, "d6_init", DutD, 16'h1234, 16'h0, 1'b0);
    count_busy(DutD, 6, "d6_busy_cycles");
    cyc(1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 1'b0, "d6_cleared", DutD, 16'h0, 16'h0, 1'b0);

    // clr during sweep cycle 3 aborts immediately; a new sweep then runs in full.
    clr_pulse();
    cyc(1'b1, 3'd4, 16'h0044, 3'd4, 3'd6, 1'b0, "ab_wr4", DutA, 16'h0044, 16'h0, 1'b0);
    cyc(1'b1, 3'd6, 16'h0066, 3'd4, 3'd6, 1'b0, "ab_wr6", DutA, 16'h0044, 16'h0066, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd4, 3'd6, 1'b1, "ab_init", DutA, 16'h0044, 16'h0066, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 3'd0, 16'h0, 3'd4, 3'd6, 1'b0, "ab_sweep", DutA, 16'h0044, 16'h0066, 1'b1);
    end
    @(posedge clk);
    #1;
    clr = 1'b1;
    expect_out("ab_clr_async", DutA, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    pop_check();
    #2;
    clr = 1'b0;
    cyc(1'b0, 3'd0, 16'h0000, 3'd4, 3'd6, 1'b0, "ab_idle", DutA, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 3'd4, 3'd6, 1'b1, "ab_reinit", DutA, 16'h0, 16'h0, 1'b0);
    count_busy(DutA, 8, "ab_busy_cycles");

    check_val("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 8, number of entries (2..256); AW = clog2(DEPTH).
REQ-003 Parameter ZERO_R0, default 0; when 1, entry 0 reads as 0 and ignores writes.
REQ-004 The clock is clk; the reset is clr, asynchronous, active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 clr  input  1  asynchronous active-high reset.
REQ-007 we  input  1  write enable, sampled at the rising edge of clk.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 ra0, ra1  input  AW each  read addresses, ports 0 and 1.
REQ-011 rd0, rd1  output  WIDTH each  read data, ports 0 and 1.
REQ-012 init_req  input  1  request for a synchronous sequential clear of all entries.
REQ-013 busy  output  1  high while the clear sweep runs.

Function
REQ-014 Write accepted = we & ~busy & (waddr < DEPTH) & ~(ZERO_R0 & waddr==0); an accepted write updates entry waddr at the clk edge.
REQ-015 Each read port is combinational: rdN = entry[raN], with zero added latency.
REQ-016 Write-first bypass: while a write is accepted and waddr==raN, rdN = wdata in the same cycle.
REQ-017 raN >= DEPTH, or ZERO_R0=1 with raN==0, drives rdN = 0; this rule has priority over bypass.
REQ-018 Both ports read independently; equal addresses on both ports return identical data.
REQ-019 FSM states: IDLE, SWEEP.
REQ-020 IDLE -> SWEEP at the edge where init_req=1; idx loads 0 and busy goes 1 at that same edge.
REQ-021 In SWEEP, each edge writes 0 to entry idx and increments idx.
REQ-022 SWEEP -> IDLE at the edge that clears entry DEPTH-1; busy is 0 from then, giving DEPTH busy cycles.
REQ-023 init_req while busy is ignored; there is no queuing or restart.
REQ-024 Writes are dropped during busy; they are not stalled or buffered, and there is no error flag.
REQ-025 A write presented in the same cycle as the accepted init_req is performed; the sweep later clears it.
REQ-026 Reads during SWEEP return current array contents: 0 for entries already cleared, old data otherwise.
REQ-027 idx wraps to 0 on SWEEP exit; it never indexes beyond DEPTH-1.

Reset
REQ-028 clr=1 immediately forces all entries to 0, state to IDLE, idx to 0 and busy to 0, without waiting for clk.
REQ-029 clr asserted mid-sweep aborts the sweep; after release the block is in IDLE with all entries 0.
REQ-030 After reset, rd0 and rd1 read 0 for every address.

Structure
REQ-031 A shared package holds the FSM state type (IDLE, SWEEP) and the clog2 helper function; WIDTH, DEPTH and ZERO_R0 remain module parameters.
REQ-032 Single module, no sub-module: the storage array, bypass/read muxes and sweep FSM form one block of about 150-250 lines.
REQ-033 Storage is an array of DEPTH by WIDTH flops, with no vendor RAM inference required.

Verification
REQ-034 Defaults; clr pulse; write 0xA5 to addr 3; then ra0=3 -> rd0=0xA5 next cycle, rd1 (ra1=4) = 0x00.
REQ-035 Bypass: we=1, waddr=5, wdata=0x3C, ra0=ra1=5 in the same cycle -> rd0=rd1=0x3C before the edge.
REQ-036 ZERO_R0=1: write 0xFF to addr 0 -> rd0 (ra0=0) stays 0x00, including during the write cycle.
REQ-037 Fill entries 0..7 with 0x11..0x88, pulse init_req -> busy high exactly 8 cycles; a write of 0x77 to addr 2 during busy is dropped; all entries read 0 afterwards.
REQ-038 DEPTH=6, WIDTH=16: write to addr 7 is ignored; ra0=7 -> rd0=0x0000; sweep busy lasts 6 cycles.
REQ-039 Assert clr at sweep cycle 3 -> busy falls immediately, state IDLE, all entries 0; a later init_req starts a new 8-cycle sweep.
